mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multi-cycle control sequencer for the MIPS datapath. It replaces the single-cycle CU decode with a state machine that drives the shared-memory multi-cycle datapath: fetch, decode, execute, memory, writeback.
- Stalls on a memory ready handshake and times out to a bus-error halt.
- Sits beside the datapath inside the CPU top. Consumes `Opcode` and `Zero`; produces all datapath enables and selects.

Parameters:
- MAX_WAIT, 255, max consecutive cycles a memory access may wait for `MemReady` before bus error (1..65535).

Ports:
- `Clock`  in  1  system clock; all state changes on rising edge
- `Reset`  in  1  synchronous, active-high reset
- `Opcode`  in  6  IR[31:26] from datapath
- `Zero`  in  1  ALU zero flag
- `MemReady`  in  1  memory completes current read/write this cycle
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemToReg`, `RegDst`, `RegWrite`, `ALUSrcA`  out  1 each  datapath controls
- `ALUSrcB`  out  2  00=B, 01=const 4, 10=sext imm, 11=sext imm<<2
- `ALUOp`  out  2  00=add, 01=sub, 10=funct decode, 11=reserved
- `PCSource`  out  2  00=ALU result, 01=ALUOut, 10=jump target
- `Halted`  out  1  illegal opcode trap reached
- `BusErr`  out  1  memory timeout trap reached

Behaviour:
- One clock. Reset is synchronous and active-high. Reset state is FETCH with wait counter 0.
- While `Reset`=1, every output is 0.
- Outputs are Moore (decoded from state), except `PCWrite`/`IRWrite` in FETCH, which are ANDed with `MemReady`.
- Default for every unlisted output is 0.
- Opcodes handled:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - addi 001000
  - anything else goes to ILLEGAL.
- States and outputs:
  - FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00; `IRWrite`=`PCWrite`=`MemReady`. Goes to DECODE on `MemReady`, else stays.
  - DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00. Goes to MEMADR (lw/sw), EXEC (R), BRANCH (beq), JUMP (j), ADDIEX (addi), ILLEGAL (other).
  - MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Goes to MEMRD (lw) or MEMWR (sw).
  - MEMRD: `MemRead`=1, `IorD`=1. Goes to MEMWB on `MemReady`.
  - MEMWB: `RegWrite`=1, `MemToReg`=1, `RegDst`=0. Goes to FETCH.
  - MEMWR: `MemWrite`=1, `IorD`=1. Goes to FETCH on `MemReady`.
  - EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Goes to RWB.
  - RWB: `RegWrite`=1, `RegDst`=1, `MemToReg`=0. Goes to FETCH.
  - BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01. Goes to FETCH. Datapath gates with `Zero`.
  - JUMP: `PCWrite`=1, `PCSource`=10. Goes to FETCH.
  - ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Goes to ADDIWB.
  - ADDIWB: `RegWrite`=1, `RegDst`=0, `MemToReg`=0. Goes to FETCH.
  - ILLEGAL: `Halted`=1. Absorbing until `Reset`.
  - BUSERR: `BusErr`=1. Absorbing until `Reset`.
- Latency (zero-wait memory): R=4, addi=4, lw=5, sw=4, beq=3, j=3 cycles.
- Wait counter, in FETCH/MEMRD/MEMWR:
  - Increments each cycle `MemReady`=0; clears on `MemReady`=1 or on leaving the state.
  - Reaching MAX_WAIT with `MemReady` still 0 goes to BUSERR next edge.
  - `MemReady`=1 in the same cycle the count reaches MAX_WAIT means the access completes normally (ready wins).
  - The counter saturates and never wraps.
- `MemRead`/`MemWrite`/`IorD` are held stable for the whole wait.
- `Reset` mid-access: next state FETCH, counter 0, trap outputs clear.
- Unused state encodings go to FETCH.
- `Opcode` is sampled only in DECODE and MEMADR. The IR is stable after FETCH.

Optional Feature:
- `MC_PERF_CNT_EN`: adds outputs `CycleCount` (32) and `RetireCount` (32).
  - `CycleCount` increments every non-reset cycle while not in a trap state.
  - `RetireCount` increments on every transition into FETCH from a non-FETCH state.
  - Both are 0 on reset and wrap modulo 2^32.
- Without the macro: ports absent, no counter logic.

Decomposition:
- Package `mc_ctrl_pkg`:
  - state enum (4-bit encoding)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - `ALUSrcB`, `ALUOp` and `PCSource` encoding constants.
- One sub-module, `mem_wait_timer`: the saturating wait counter with MAX_WAIT compare. Inputs: active, ready. Output: timeout.

Test Plan:
- Reset held 3 cycles then released, `MemReady`=1 → state FETCH, `MemRead`=1 first cycle; during reset all outputs 0.
- `Opcode`=100011 (lw), `MemReady` always 1 → sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH in 5 cycles; `RegWrite`=1, `MemToReg`=1 only in cycle 5.
- sw with `MemReady` low for 3 cycles in MEMWR → `MemWrite`=1, `IorD`=1 held 4 cycles, then FETCH; `RegWrite` never asserted.
- MAX_WAIT=4, `MemReady` stuck 0 in FETCH → `BusErr`=1 after 4 wait cycles; stays through 10 more cycles; `Reset` clears it.
- `Opcode`=111111 → ILLEGAL after DECODE, `Halted`=1, no `PCWrite`/`RegWrite`/`MemWrite` thereafter.
- beq with `Zero`=1 then j → BRANCH asserts `PCWriteCond`=1, `PCSource`=01, `ALUOp`=01; JUMP asserts `PCWrite`=1, `PCSource`=10; each 3 cycles. With `MC_PERF_CNT_EN`, `RetireCount`=2.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// Shared types and constants for the multi-cycle MIPS control sequencer:
// state encoding, opcodes, datapath select encodings and the per-state control decode.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXEC    = 4'd6,
        ST_RWB     = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_JUMP    = 4'd9,
        ST_ADDIEX  = 4'd10,
        ST_ADDIWB  = 4'd11,
        ST_ILLEGAL = 4'd12,
        ST_BUSERR  = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // fetch marks the state whose PCWrite/IRWrite follow MemReady
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       halted;
        logic       bus_err;
        logic       fetch;
    } ctl_t;

    function automatic ctl_t ctl_decode(state_e st);
        ctl_t c;
        c = ctl_t'(18'd0);
        case (st)
            ST_FETCH:   begin c.mem_read = 1'b1; c.alu_src_b = SRCB_FOUR; c.fetch = 1'b1; end
            ST_DECODE:  begin c.alu_src_b = SRCB_IMM_SH2; c.alu_op = ALUOP_ADD; end
            ST_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
            ST_MEMRD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
            ST_MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            ST_MEMWR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
            ST_EXEC:    begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_B; c.alu_op = ALUOP_FUNCT; end
            ST_RWB:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            ST_BRANCH:  begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP:    begin c.pc_write = 1'b1; c.pc_source = PCSRC_JUMP; end
            ST_ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
            ST_ADDIWB:  begin c.reg_write = 1'b1; end
            ST_ILLEGAL: begin c.halted = 1'b1; end
            ST_BUSERR:  begin c.bus_err = 1'b1; end
            default:    begin c = ctl_t'(18'd0); end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath bundle: datapath status in, control enables and selects out.
interface mc_control_fsm_if;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemToReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       Halted;
    logic       BusErr;

    modport master (
        input  Opcode, Zero, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Halted, BusErr
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Halted, BusErr
    );
endinterface

// File: rtl/mc_control_fsm_mem_wait_timer.sv
// Saturating memory wait counter; flags timeout when the MAX_WAIT-th consecutive
// not-ready cycle is in progress (a ready in that same cycle still wins).
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic timeout
);
    localparam logic [16:0] LIMIT = 17'(MAX_WAIT);

    logic [15:0] cnt_r;
    logic        at_limit_s;

    assign at_limit_s = ({1'b0, cnt_r} + 17'd1) >= LIMIT;
    assign timeout    = active & ~ready & at_limit_s;

    // count consecutive not-ready cycles, clearing on ready or when no access is pending
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 16'd0;
        end else if (!active || ready) begin
            cnt_r <= 16'd0;
        end else if ({1'b0, cnt_r} < LIMIT) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer. Define MC_PERF_CNT_EN to add the
// CycleCount/RetireCount performance counter outputs.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic              Clock,
    input  logic              Reset,
    mc_control_fsm_if.master  bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]       CycleCount,
    output logic [31:0]       RetireCount
`endif
);
    state_e state_r;
    state_e nxt_s;
    ctl_t   ctl_r;
    logic   active_s;
    logic   timeout_s;
    logic   run_s;

    assign active_s = (state_r == ST_FETCH) || (state_r == ST_MEMRD) || (state_r == ST_MEMWR);
    assign run_s    = ~Reset;

    mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk     (Clock),
        .rst     (Reset),
        .active  (active_s),
        .ready   (bus.MemReady),
        .timeout (timeout_s)
    );

    // next-state selection; Opcode is only looked at in DECODE and MEMADR
    always_comb begin
        nxt_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (bus.MemReady)   nxt_s = ST_DECODE;
                else if (timeout_s) nxt_s = ST_BUSERR;
                else                nxt_s = ST_FETCH;
            end
            ST_DECODE: begin
                case (bus.Opcode)
                    OP_LW, OP_SW: nxt_s = ST_MEMADR;
                    OP_RTYPE:     nxt_s = ST_EXEC;
                    OP_BEQ:       nxt_s = ST_BRANCH;
                    OP_J:         nxt_s = ST_JUMP;
                    OP_ADDI:      nxt_s = ST_ADDIEX;
                    default:      nxt_s = ST_ILLEGAL;
                endcase
            end
            ST_MEMADR: begin
                if (bus.Opcode == OP_LW) nxt_s = ST_MEMRD;
                else                     nxt_s = ST_MEMWR;
            end
            ST_MEMRD: begin
                if (bus.MemReady)   nxt_s = ST_MEMWB;
                else if (timeout_s) nxt_s = ST_BUSERR;
                else                nxt_s = ST_MEMRD;
            end
            ST_MEMWR: begin
                if (bus.MemReady)   nxt_s = ST_FETCH;
                else if (timeout_s) nxt_s = ST_BUSERR;
                else                nxt_s = ST_MEMWR;
            end
            ST_MEMWB, ST_RWB, ST_BRANCH, ST_JUMP, ST_ADDIWB: nxt_s = ST_FETCH;
            ST_EXEC:    nxt_s = ST_RWB;
            ST_ADDIEX:  nxt_s = ST_ADDIWB;
            ST_ILLEGAL: nxt_s = ST_ILLEGAL;
            ST_BUSERR:  nxt_s = ST_BUSERR;
            default:    nxt_s = ST_FETCH;
        endcase
    end

    // state register with control word registered alongside so outputs never glitch on decode
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= ST_FETCH;
            ctl_r   <= ctl_decode(ST_FETCH);
        end else begin
            state_r <= nxt_s;
            ctl_r   <= ctl_decode(nxt_s);
        end
    end

    // Reset forces every output low; FETCH PC/IR writes follow MemReady
    assign bus.PCWrite     = run_s & (ctl_r.pc_write | (ctl_r.fetch & bus.MemReady));
    assign bus.IRWrite     = run_s & ctl_r.fetch & bus.MemReady;
    assign bus.PCWriteCond = run_s & ctl_r.pc_write_cond;
    assign bus.IorD        = run_s & ctl_r.iord;
    assign bus.MemRead     = run_s & ctl_r.mem_read;
    assign bus.MemWrite    = run_s & ctl_r.mem_write;
    assign bus.MemToReg    = run_s & ctl_r.mem_to_reg;
    assign bus.RegDst      = run_s & ctl_r.reg_dst;
    assign bus.RegWrite    = run_s & ctl_r.reg_write;
    assign bus.ALUSrcA     = run_s & ctl_r.alu_src_a;
    assign bus.ALUSrcB     = {2{run_s}} & ctl_r.alu_src_b;
    assign bus.ALUOp       = {2{run_s}} & ctl_r.alu_op;
    assign bus.PCSource    = {2{run_s}} & ctl_r.pc_source;
    assign bus.Halted      = run_s & ctl_r.halted;
    assign bus.BusErr      = run_s & ctl_r.bus_err;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_r;
    logic [31:0] retire_cnt_r;
    logic        trap_s;

    assign trap_s = (state_r == ST_ILLEGAL) || (state_r == ST_BUSERR);

    // cycles outside the trap states and completed instructions (re-entries into FETCH)
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cycle_cnt_r  <= 32'd0;
            retire_cnt_r <= 32'd0;
        end else begin
            if (!trap_s) cycle_cnt_r <= cycle_cnt_r + 32'd1;
            else         cycle_cnt_r <= cycle_cnt_r;
            if ((nxt_s == ST_FETCH) && (state_r != ST_FETCH)) retire_cnt_r <= retire_cnt_r + 32'd1;
            else                                              retire_cnt_r <= retire_cnt_r;
        end
    end

    assign CycleCount  = run_s ? cycle_cnt_r  : 32'd0;
    assign RetireCount = run_s ? retire_cnt_r : 32'd0;
`endif
endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized scoreboard bench for mc_control_fsm: an instruction-level model
// queues the expected control word for every cycle, a monitor compares each one.
module tb_mc_control_fsm;
    localparam int MW = 4;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_ADDI = 6'b001000;

    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_EXEC,
        P_RWB, P_BRANCH, P_JUMP, P_ADDIEX, P_ADDIWB, P_ILLEGAL, P_BUSERR
    } phase_e;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       m2r;
        logic       rdst;
        logic       rwr;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       halt;
        logic       berr;
    } word_t;

    typedef struct {
        word_t       w;
        logic [31:0] cyc;
        logic [31:0] ret;
        phase_e      ph;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mc_control_fsm_if io();
`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_cnt;
    logic [31:0] ret_cnt;
`endif

    mc_control_fsm #(.MAX_WAIT(MW)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (io)
`ifdef MC_PERF_CNT_EN
        ,
        .CycleCount  (cyc_cnt),
        .RetireCount (ret_cnt)
`endif
    );

    always #5 clk = ~clk;

    item_t       sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc_no   = 0;
    logic [31:0] exp_cyc  = 32'd0;
    logic [31:0] exp_ret  = 32'd0;

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // control word each phase must present, straight from the state/output table
    function automatic word_t expect_word(phase_e ph, logic rdy);
        word_t w;
        w = word_t'(17'd0);
        case (ph)
            P_FETCH:   begin w.mrd = 1'b1; w.srcb = 2'b01; w.irw = rdy; w.pcw = rdy; end
            P_DECODE:  begin w.srcb = 2'b11; end
            P_MEMADR:  begin w.srca = 1'b1; w.srcb = 2'b10; end
            P_MEMRD:   begin w.mrd = 1'b1; w.iord = 1'b1; end
            P_MEMWB:   begin w.rwr = 1'b1; w.m2r = 1'b1; end
            P_MEMWR:   begin w.mwr = 1'b1; w.iord = 1'b1; end
            P_EXEC:    begin w.srca = 1'b1; w.aluop = 2'b10; end
            P_RWB:     begin w.rwr = 1'b1; w.rdst = 1'b1; end
            P_BRANCH:  begin w.srca = 1'b1; w.aluop = 2'b01; w.pcwc = 1'b1; w.pcsrc = 2'b01; end
            P_JUMP:    begin w.pcw = 1'b1; w.pcsrc = 2'b10; end
            P_ADDIEX:  begin w.srca = 1'b1; w.srcb = 2'b10; end
            P_ADDIWB:  begin w.rwr = 1'b1; end
            P_ILLEGAL: begin w.halt = 1'b1; end
            P_BUSERR:  begin w.berr = 1'b1; end
            default:   begin w = word_t'(17'd0); end
        endcase
        return w;
    endfunction

    // one clock of stimulus; ends=1 when this cycle retires an instruction into FETCH
    task automatic cycle(phase_e ph, logic rdy, logic [5:0] op, bit ends, bit rs);
        item_t it;
        @(posedge clk);
        #1;
        rst         = rs;
        io.MemReady = rdy;
        io.Opcode   = op;
        io.Zero     = rnd_bit();
        it.ph  = ph;
        it.w   = rs ? word_t'(17'd0) : expect_word(ph, rdy);
        it.cyc = rs ? 32'd0 : exp_cyc;
        it.ret = rs ? 32'd0 : exp_ret;
        sb_q.push_back(it);
        if (rs) begin
            exp_cyc = 32'd0;
            exp_ret = 32'd0;
        end else begin
            if (ph != P_ILLEGAL && ph != P_BUSERR) exp_cyc = exp_cyc + 32'd1;
            if (ends) exp_ret = exp_ret + 32'd1;
        end
    endtask

    task automatic do_reset(int n);
        for (int i = 0; i < n; i++) cycle(P_FETCH, rnd_bit(), rnd_op(), 1'b0, 1'b1);
    endtask

    task automatic trap(phase_e ph, int n);
        for (int i = 0; i < n; i++) cycle(ph, rnd_bit(), rnd_op(), 1'b0, 1'b0);
    endtask

    // memory access with 'waits' not-ready cycles; MW of them in a row is a bus error
    task automatic mem_access(phase_e ph, int waits, bit ends, output bit to);
        for (int i = 0; i < waits && i < MW; i++) cycle(ph, 1'b0, rnd_op(), 1'b0, 1'b0);
        if (waits >= MW) begin
            to = 1'b1;
        end else begin
            cycle(ph, 1'b1, rnd_op(), ends, 1'b0);
            to = 1'b0;
        end
    endtask

    task automatic run_instr(logic [5:0] op, int fw, int mw);
        bit to;
        mem_access(P_FETCH, fw, 1'b0, to);
        if (to) begin
            trap(P_BUSERR, 10);
            do_reset(2);
        end else begin
            cycle(P_DECODE, rnd_bit(), op, 1'b0, 1'b0);
            case (op)
                T_R: begin
                    cycle(P_EXEC, rnd_bit(), rnd_op(), 1'b0, 1'b0);
                    cycle(P_RWB, rnd_bit(), rnd_op(), 1'b1, 1'b0);
                end
                T_ADDI: begin
                    cycle(P_ADDIEX, rnd_bit(), rnd_op(), 1'b0, 1'b0);
                    cycle(P_ADDIWB, rnd_bit(), rnd_op(), 1'b1, 1'b0);
                end
                T_LW: begin
                    cycle(P_MEMADR, rnd_bit(), op, 1'b0, 1'b0);
                    mem_access(P_MEMRD, mw, 1'b0, to);
                    if (to) begin
                        trap(P_BUSERR, 10);
                        do_reset(2);
                    end else begin
                        cycle(P_MEMWB, rnd_bit(), rnd_op(), 1'b1, 1'b0);
                    end
                end
                T_SW: begin
                    cycle(P_MEMADR, rnd_bit(), op, 1'b0, 1'b0);
                    mem_access(P_MEMWR, mw, 1'b1, to);
                    if (to) begin
                        trap(P_BUSERR, 10);
                        do_reset(2);
                    end
                end
                T_BEQ:   cycle(P_BRANCH, rnd_bit(), rnd_op(), 1'b1, 1'b0);
                T_J:     cycle(P_JUMP, rnd_bit(), rnd_op(), 1'b1, 1'b0);
                default: begin
                    trap(P_ILLEGAL, 6);
                    do_reset(2);
                end
            endcase
        end
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] op;
        case ($urandom_range(0, 12))
            0, 1:    op = T_R;
            2, 3:    op = T_ADDI;
            4, 5, 6: op = T_LW;
            7, 8:    op = T_SW;
            9, 10:   op = T_BEQ;
            11:      op = T_J;
            default: begin
                op = rnd_op();
                while (op == T_R || op == T_ADDI || op == T_LW || op == T_SW || op == T_BEQ || op == T_J)
                    op = rnd_op();
            end
        endcase
        return op;
    endfunction

    function automatic int pick_wait();
        if ($urandom_range(0, 19) == 0) return int'($urandom_range(MW, MW + 2));
        return int'($urandom_range(0, MW - 1));
    endfunction

    // monitor: every queued cycle is compared against the live DUT outputs mid-cycle
    item_t mon_it;
    word_t mon_act;
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                mon_it  = sb_q.pop_front();
                mon_act = {io.PCWrite, io.PCWriteCond, io.IorD, io.MemRead, io.MemWrite, io.IRWrite,
                           io.MemToReg, io.RegDst, io.RegWrite, io.ALUSrcA, io.ALUSrcB, io.ALUOp,
                           io.PCSource, io.Halted, io.BusErr};
                cyc_no++;
                n_checks++;
                if (mon_act !== mon_it.w) begin
                    n_fail++;
                    $display("FAIL ctl cycle=%0d phase=%s got=%h exp=%h", cyc_no, mon_it.ph.name(), mon_act, mon_it.w);
                end
`ifdef MC_PERF_CNT_EN
                n_checks++;
                if (cyc_cnt !== mon_it.cyc) begin
                    n_fail++;
                    $display("FAIL cycle_count cycle=%0d got=%0d exp=%0d", cyc_no, cyc_cnt, mon_it.cyc);
                end
                n_checks++;
                if (ret_cnt !== mon_it.ret) begin
                    n_fail++;
                    $display("FAIL retire_count cycle=%0d got=%0d exp=%0d", cyc_no, ret_cnt, mon_it.ret);
                end
`endif
            end
        end
    end

    initial begin
        io.MemReady = 1'b0;
        io.Opcode   = 6'd0;
        io.Zero     = 1'b0;
        do_reset(3);
        run_instr(T_LW, 0, 0);
        run_instr(T_SW, 0, 3);
        run_instr(T_R, MW + 3, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(T_BEQ, 0, 0);
        run_instr(T_J, 0, 0);
        run_instr(T_LW, MW - 1, MW - 1);
        run_instr(T_SW, 1, MW);
        run_instr(T_ADDI, 2, 0);
        // reset while a load is waiting on memory
        cycle(P_FETCH, 1'b1, rnd_op(), 1'b0, 1'b0);
        cycle(P_DECODE, rnd_bit(), T_LW, 1'b0, 1'b0);
        cycle(P_MEMADR, rnd_bit(), T_LW, 1'b0, 1'b0);
        cycle(P_MEMRD, 1'b0, rnd_op(), 1'b0, 1'b0);
        cycle(P_MEMRD, 1'b0, rnd_op(), 1'b0, 1'b0);
        cycle(P_FETCH, 1'b0, rnd_op(), 1'b0, 1'b1);
        run_instr(T_R, MW - 1, 0);
        for (int n = 0; n < 200; n++) run_instr(pick_op(), pick_wait(), pick_wait());
        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d pending exp=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
